// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state type, frame constants and 3-sample majority vote
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_OVERSAMPLE_DEF = 16;
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_baud_tick.sv
// uart_rx_baud_tick: divides clk by max(baud_divisor,1) into a one-cycle oversample tick
module uart_rx_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_divisor,
  output logic             tick
);
  logic [DIV_W-1:0] cnt, last;
  assign last = (baud_divisor == '0) ? '0 : baud_divisor - 1'b1;
  // >= so a divisor lowered mid-count wraps at once instead of rolling over
  assign tick = cnt >= last;
  always_ff @(posedge clk) begin
    cnt <= (reset || tick) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled 8N1 UART receiver with 1-entry valid/ready holding register
// Define UART_RX_PARITY_EN for an extra parity bit (parity_odd selects odd/even, parity_error pulse).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int DIV_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic [DIV_W-1:0]          baud_divisor,
  input  logic                      data_ready,
`ifdef UART_RX_PARITY_EN
  input  logic                      parity_odd,
  output logic                      parity_error,
`endif
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      data_valid,
  output logic                      start_bit,
  output logic                      framing_error,
  output logic                      overrun,
  output logic                      busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_END = IW'(UART_DATA_BITS - 1);
  rx_state_e state, nstate;
  logic sync1, rx, prev_rx, tick, maj, dec, bend, stop_dec, good, load, par_bad;
  logic [SW-1:0] s;
  logic [IW-1:0] idx;
  logic [1:0] samp;
  logic [UART_DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_bad = ((^shreg) ^ par_bit) != parity_odd;
`else
  assign par_bad = 1'b0;
`endif
  uart_rx_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk          (clk),
    .reset        (reset),
    .baud_divisor (baud_divisor),
    .tick         (tick)
  );
  assign busy = state != IDLE;
  always_comb begin
    nstate   = state;
    maj      = majority3(samp[1], samp[0], rx);
    dec      = tick && s == S_HI;
    bend     = tick && s == S_END;
    stop_dec = state == STOP && dec;
    good     = stop_dec && maj && !par_bad;
    load     = good && (!data_valid || data_ready);
    case (state)
      IDLE:   nstate = (tick && prev_rx && !rx) ? START : IDLE;
      START:  nstate = (dec && maj) ? IDLE : bend ? DATA : START;
`ifdef UART_RX_PARITY_EN
      DATA:   nstate = (bend && idx == I_END) ? PARITY : DATA;
      PARITY: nstate = bend ? STOP : PARITY;
`else
      DATA:   nstate = (bend && idx == I_END) ? STOP : DATA;
`endif
      STOP:   nstate = dec ? IDLE : STOP;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {rx, sync1}   <= 2'b11;
      prev_rx       <= 1'b0;
      state         <= IDLE;
      s             <= '0;
      idx           <= '0;
      samp          <= '0;
      shreg         <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      start_bit     <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      {rx, sync1}   <= {sync1, rx_in};
      if (tick) prev_rx <= rx;
      state         <= nstate;
      s             <= (state == IDLE) ? '0 : tick ? s + 1'b1 : s;
      idx           <= (state != DATA) ? '0 : bend ? idx + 1'b1 : idx;
      if (tick && s == S_LO) samp[1] <= rx;
      if (tick && s == S_MID) samp[0] <= rx;
      if (state == DATA && dec) shreg[idx] <= maj;
      start_bit     <= state == START && dec && !maj;
      framing_error <= stop_dec && !maj;
      overrun       <= good && data_valid && !data_ready;
      if (load) data_out <= shreg;
      data_valid    <= load || (data_valid && !data_ready);
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && dec) par_bit <= maj;
      parity_error  <= stop_dec && par_bad;
`endif
    end
  end
endmodule
